// File: rtl/frame_sequencer_pkg.sv
// Shared types for the per-frame clear/draw render sequencer.
package frame_sequencer_pkg;

  localparam int XW_DEF = 10;
  localparam int YW_DEF = 10;

  typedef logic [XW_DEF-1:0] coord_x_t;
  typedef logic [YW_DEF-1:0] coord_y_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_edge_detect.sv
// Registered rising-edge detector; rise is high one cycle after in is first sampled high.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic rise_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      in_q   <= in;
      rise_q <= in & ~in_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: on each frame_clk rise runs clear then draw, muxes both engines
// onto one frame-buffer write port and swaps front/back buffers between frames.
//
// state | meaning
// IDLE  | after reset, waiting for the first frame edge
// CLEAR | clear engine owns the write port
// DRAW  | draw engine owns the write port
// DONE  | back buffer complete, waiting for the next frame edge
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int             XW          = XW_DEF,
  parameter int             YW          = YW_DEF,
  parameter int             BPP         = 1,
  parameter logic [BPP-1:0] CLEAR_COLOR = '0,
  parameter bit             DOUBLE_BUF  = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  input  logic           clear_en,
  input  logic           clear_done,
  input  logic [XW-1:0]  clear_DrawX,
  input  logic [YW-1:0]  clear_DrawY,
  input  logic           draw_done,
  input  logic [XW-1:0]  draw_DrawX,
  input  logic [YW-1:0]  draw_DrawY,
  input  logic [BPP-1:0] draw_data,
  input  logic           draw_we,
  output logic           clear_start,
  output logic           draw_start,
  output logic [XW-1:0]  DrawX,
  output logic [YW-1:0]  DrawY,
  output logic [BPP-1:0] wr_data,
  output logic           wr_en,
  output logic           frame_clk_rising_edge,
  output logic           frame_done,
  output logic           back_sel,
  output logic           frame_overrun
);

  seq_state_t state_q, state_d;
  logic       back_sel_q, back_sel_d;
  logic       clear_start_q, draw_start_q;
  logic       rise;

  edge_detect u_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (frame_clk),
    .rise  (rise)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      back_sel_q    <= 1'b0;
      clear_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      back_sel_q    <= back_sel_d;
      clear_start_q <= (state_d == CLEAR) && (state_q != CLEAR);
      draw_start_q  <= (state_d == DRAW) && (state_q != DRAW);
    end
  end

  // A done seen during the start cycle belongs to the previous run, so it is ignored.
  always_comb begin
    state_d    = state_q;
    back_sel_d = back_sel_q;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = clear_en ? CLEAR : DRAW;
      end
      CLEAR: begin
        if (clear_done && !clear_start_q) state_d = DRAW;
      end
      DRAW: begin
        if (draw_done && !draw_start_q) state_d = DONE;
      end
      DONE: begin
        if (rise) begin
          state_d = clear_en ? CLEAR : DRAW;
          if (DOUBLE_BUF) back_sel_d = ~back_sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by Reset so the write port goes quiet in the reset cycle itself.
  always_comb begin
    DrawX   = '0;
    DrawY   = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        DrawX   = clear_DrawX;
        DrawY   = clear_DrawY;
        wr_data = CLEAR_COLOR;
        wr_en   = ~Reset;
      end
      DRAW: begin
        DrawX   = draw_DrawX;
        DrawY   = draw_DrawY;
        wr_data = draw_data;
        wr_en   = draw_we & ~Reset;
      end
      default: ;
    endcase
    clear_start           = clear_start_q & ~Reset;
    draw_start            = draw_start_q & ~Reset;
    frame_clk_rising_edge = rise;
    frame_done            = (state_q == DONE);
    back_sel              = back_sel_q;
    frame_overrun         = rise && ((state_q == CLEAR) || (state_q == DRAW));
  end

endmodule
